// File: rtl/cache_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_bus_pkg
// Description : Shared types and helpers for the cache bus controller:
//               bus operation codes, snoop responses, FSM states and a
//               32-bit saturating increment used by the optional statistics.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_bus_pkg;

  // Bus operation encoding; identical on the cache side and on the bus.
  typedef enum logic [1:0] {
    READ      = 2'd0,  // BusRd
    RFO       = 2'd1,  // BusRdX
    UPGRADE   = 2'd2,  // BusUpgr
    WRITEBACK = 2'd3   // Flush
  } bus_op_t;

  // Snoop response. The enum literals double as the NOHIT/HIT/HITM
  // constants (0/1/2); the raw bus code 3 has no literal and decodes to NOHIT.
  typedef enum logic [1:0] {
    NOHIT = 2'd0,
    HIT   = 2'd1,
    HITM  = 2'd2
  } snoop_t;

  // Controller FSM states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ARB  = 3'd1,
    ADDR = 3'd2,
    MEM  = 3'd3,
    DONE = 3'd4
  } bus_state_t;

  // Map the raw 2-bit snoop bus onto snoop_t; the reserved code means no hit.
  function automatic snoop_t decode_snoop(input logic [1:0] raw);
    case (raw)
      2'd1:    decode_snoop = HIT;
      2'd2:    decode_snoop = HITM;
      default: decode_snoop = NOHIT;
    endcase
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    sat_inc = (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage : cache_bus_pkg
`default_nettype wire

// File: rtl/cache_bus_timeout.sv
`default_nettype none
// ============================================================================
// Module      : cache_bus_timeout
// Description : Memory wait counter. Cleared before MEM is entered, counts
//               each MEM cycle, and flags expiry in the MEM_TIMEOUT-th wait
//               cycle so the controller leaves MEM after exactly MEM_TIMEOUT
//               cycles without mem_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_bus_timeout #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstb,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // A timeout below one cycle is meaningless; treat it as one.
  localparam int c_lim   = (MEM_TIMEOUT < 1) ? 1 : MEM_TIMEOUT;
  localparam int c_cnt_w = (c_lim < 2) ? 1 : $clog2(c_lim);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_lim - 1);

  logic [c_cnt_w-1:0] r_count;

  // The count equals the number of MEM cycles already completed.
  assign expired = enable && (r_count == c_last);

  // Wait counter: clear wins, otherwise count MEM cycles up to the limit.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule : cache_bus_timeout
`default_nettype wire

// File: rtl/cache_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_bus_ctrl
// Description : Single-outstanding cache-to-bus controller. Accepts one
//               MESI bus operation, arbitrates, drives the address phase,
//               samples the snoop result, waits for memory (with timeout)
//               and returns done/shared/err to the cache.
//               Optional macro CACHE_BUS_STATS_EN adds three saturating
//               statistics counters (stat_ops, stat_hitm, stat_timeouts).
// Revision    : 1.0 - initial release
// ============================================================================
module cache_bus_ctrl
  import cache_bus_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              done,
  output logic              shared,
  output logic              err,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [1:0]        bus_op,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic [1:0]        bus_snoop,
  output logic              mem_valid,
  input  logic              mem_ready
`ifdef CACHE_BUS_STATS_EN
  ,
  output logic [31:0]       stat_ops,
  output logic [31:0]       stat_hitm,
  output logic [31:0]       stat_timeouts
`endif
);

  bus_state_t        r_state;
  bus_op_t           r_op;
  logic [ADDR_W-1:0] r_addr;
  snoop_t            r_snoop;

  logic w_tmo_clear;
  logic w_tmo_en;
  logic w_tmo_expired;
  logic w_shared_next;

  // The counter is zeroed during ADDR so it starts from 0 on MEM entry.
  assign w_tmo_clear = (r_state == ADDR);
  assign w_tmo_en    = (r_state == MEM);

  // Only a READ that another cache holds ends up in Shared.
  assign w_shared_next = (r_op == READ) && ((r_snoop == HIT) || (r_snoop == HITM));

  cache_bus_timeout #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rstb    (rstb),
    .clear   (w_tmo_clear),
    .enable  (w_tmo_en),
    .expired (w_tmo_expired)
  );

  // Controller FSM; every output is registered alongside the next state.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state   <= IDLE;
      r_op      <= READ;
      r_addr    <= '0;
      r_snoop   <= NOHIT;
      req_ready <= 1'b1;
      done      <= 1'b0;
      shared    <= 1'b0;
      err       <= 1'b0;
      bus_req   <= 1'b0;
      bus_op    <= 2'd0;
      bus_addr  <= '0;
      mem_valid <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      shared   <= 1'b0;
      bus_op   <= 2'd0;
      bus_addr <= '0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_op      <= bus_op_t'(req_op);
            r_addr    <= req_addr;
            req_ready <= 1'b0;
            bus_req   <= 1'b1;
            r_state   <= ARB;
          end
        end
        ARB: begin
          if (bus_gnt) begin
            bus_op   <= r_op;
            bus_addr <= r_addr;
            r_state  <= ADDR;
          end
        end
        ADDR: begin
          r_snoop <= decode_snoop(bus_snoop);
          if (r_op == UPGRADE) begin
            // An upgrade needs no data; READ is impossible here so shared stays 0.
            done    <= 1'b1;
            bus_req <= 1'b0;
            r_state <= DONE;
          end else begin
            // HITM still waits on memory: the owner's flush is serviced there.
            mem_valid <= 1'b1;
            r_state   <= MEM;
          end
        end
        MEM: begin
          // mem_ready takes priority over an expiry in the same cycle.
          if (mem_ready || w_tmo_expired) begin
            done      <= 1'b1;
            err       <= !mem_ready;
            shared    <= w_shared_next;
            mem_valid <= 1'b0;
            bus_req   <= 1'b0;
            r_state   <= DONE;
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          r_state   <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          bus_req   <= 1'b0;
          mem_valid <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_BUS_STATS_EN
  // Statistics: completed operations, HITM snoops and memory timeouts.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      stat_ops      <= '0;
      stat_hitm     <= '0;
      stat_timeouts <= '0;
    end else begin
      if (done) begin
        stat_ops <= sat_inc(stat_ops);
      end
      if (err) begin
        stat_timeouts <= sat_inc(stat_timeouts);
      end
      if ((r_state == ADDR) && (decode_snoop(bus_snoop) == HITM)) begin
        stat_hitm <= sat_inc(stat_hitm);
      end
    end
  end
`endif

endmodule : cache_bus_ctrl
`default_nettype wire

// File: tb/tb_cache_bus_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cache_bus_ctrl
// Description : Self-checking bench for cache_bus_ctrl: a table of bus
//               operations with expected timing and results, a done/err
//               scoreboard, and hand-written back-to-back and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_bus_ctrl;
  import cache_bus_pkg::*;

  localparam int ADDR_W      = 32;
  localparam int MEM_TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              rstb = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [1:0]        req_op = 2'd0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              done;
  logic              shared;
  logic              err;
  logic              bus_req;
  logic              bus_gnt = 1'b0;
  logic [1:0]        bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic [1:0]        bus_snoop = 2'd0;
  logic              mem_valid;
  logic              mem_ready = 1'b0;
`ifdef CACHE_BUS_STATS_EN
  logic [31:0]       stat_ops;
  logic [31:0]       stat_hitm;
  logic [31:0]       stat_timeouts;
`endif

  always #5 clk = ~clk;

  cache_bus_ctrl #(
    .ADDR_W      (ADDR_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rstb          (rstb),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .done          (done),
    .shared        (shared),
    .err           (err),
    .bus_req       (bus_req),
    .bus_gnt       (bus_gnt),
    .bus_op        (bus_op),
    .bus_addr      (bus_addr),
    .bus_snoop     (bus_snoop),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready)
`ifdef CACHE_BUS_STATS_EN
    ,
    .stat_ops      (stat_ops),
    .stat_hitm     (stat_hitm),
    .stat_timeouts (stat_timeouts)
`endif
  );

  // One operation: stimulus plus everything the bench expects back.
  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] addr;
    int          gnt_delay;   // ARB cycles with bus_gnt=0 before the grant
    logic [1:0]  snoop;       // value on bus_snoop during ADDR
    int          mem_delay;   // MEM cycle carrying mem_ready (0 = never)
    logic        exp_shared;
    logic        exp_err;
    int          exp_lat;     // cycles from acceptance to done
    int          exp_memv;    // cycles with mem_valid high
  } vec_t;

  typedef struct {
    logic shared;
    logic err;
  } exp_t;

  localparam int NVEC = 8;
  vec_t vecs [NVEC];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input string name, input logic [1:0] op,
                         input logic [31:0] addr, input int gd, input logic [1:0] sn,
                         input int md, input logic sh, input logic er,
                         input int lat, input int memv);
    vecs[i] = '{name, op, addr, gd, sn, md, sh, er, lat, memv};
  endtask

  // Scoreboard consumer: every done must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rstb && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        e = sb.pop_front();
        chk("done_shared", {63'd0, shared}, {63'd0, e.shared});
        chk("done_err", {63'd0, err}, {63'd0, e.err});
      end
    end
  end

  // Drive one operation from the acceptance cycle through done, then one IDLE cycle.
  task automatic run_op(input vec_t v, input bit hold, input logic [1:0] nxt_op,
                        input logic [31:0] nxt_addr);
    int cyc, waitc, a, memv, lat, rr_bad, ba_bad;
    bit fin;
    req_valid = 1'b1;
    req_op    = v.op;
    req_addr  = v.addr;
    waitc = 0;
    while (!req_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    chk({v.name, "_accept_ready"}, {63'd0, req_ready}, 64'd1);
    sb.push_back('{shared: v.exp_shared, err: v.exp_err});
    a = v.gnt_delay + 2;
    cyc = 0; fin = 0; memv = 0; lat = -1; rr_bad = 0; ba_bad = 0;
    while (!fin && cyc < MEM_TIMEOUT + 40) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        req_op   = nxt_op;
        req_addr = nxt_addr;
      end else begin
        req_valid = 1'b0;
      end
      if (mem_valid) memv++;
      if (req_ready) rr_bad++;
      if (cyc == a) begin
        chk({v.name, "_addr_op"}, {62'd0, bus_op}, {62'd0, v.op});
        chk({v.name, "_addr_addr"}, {32'd0, bus_addr}, {32'd0, v.addr});
        chk({v.name, "_addr_busreq"}, {63'd0, bus_req}, 64'd1);
      end else if (bus_op != 2'd0 || bus_addr != '0) begin
        ba_bad++;
      end
      if (done) begin
        fin = 1;
        lat = cyc;
        chk({v.name, "_done_busreq"}, {63'd0, bus_req}, 64'd0);
        chk({v.name, "_done_memvalid"}, {63'd0, mem_valid}, 64'd0);
        bus_gnt = 1'b0; mem_ready = 1'b0; bus_snoop = 2'd0;
      end else begin
        // Grant and mem_ready are also pulsed where they must be ignored.
        bus_gnt   = (cyc == v.gnt_delay + 1) || (cyc > a);
        mem_ready = (cyc < v.gnt_delay + 1) ||
                    (v.mem_delay > 0 && cyc == a + v.mem_delay);
        bus_snoop = (cyc == a) ? v.snoop : 2'b11;
      end
    end
    chk({v.name, "_latency"}, 64'(lat), 64'(v.exp_lat));
    chk({v.name, "_memvalid_cycles"}, 64'(memv), 64'(v.exp_memv));
    chk({v.name, "_ready_busy"}, 64'(rr_bad), 64'd0);
    chk({v.name, "_busaddr_outside"}, 64'(ba_bad), 64'd0);
    @(negedge clk);
    chk({v.name, "_idle_ready"}, {63'd0, req_ready}, 64'd1);
    chk({v.name, "_idle_busreq"}, {63'd0, bus_req}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t b1, b2, up;
    int   ncyc;
    // name          op         addr          gd snoop md  sh er  lat memv
    set_vec(0, "read_hit",   READ,      32'h0000_1040, 2, 2'd1, 1,   1'b1, 1'b0, 6,   1);
    set_vec(1, "upgrade",    UPGRADE,   32'hDEAD_BEC0, 0, 2'd1, 0,   1'b0, 1'b0, 3,   0);
    set_vec(2, "rfo_hitm",   RFO,       32'h0000_2000, 0, 2'd2, 5,   1'b0, 1'b0, 8,   5);
    set_vec(3, "wb_timeout", WRITEBACK, 32'h0000_3000, 0, 2'd0, 0,   1'b0, 1'b1, 258, 255);
    set_vec(4, "read_hitm",  READ,      32'h0000_4440, 1, 2'd2, 3,   1'b1, 1'b0, 7,   3);
    set_vec(5, "read_snp3",  READ,      32'h0000_5000, 0, 2'd3, 2,   1'b0, 1'b0, 5,   2);
    set_vec(6, "wb_hit",     WRITEBACK, 32'h0000_6000, 3, 2'd1, 1,   1'b0, 1'b0, 7,   1);
    set_vec(7, "rfo_last",   RFO,       32'h0000_7000, 0, 2'd1, 255, 1'b0, 1'b0, 258, 255);

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_flags", {58'd0, done, shared, err, bus_req, mem_valid, 1'b0}, 64'd0);
    chk("rst_bus_op", {62'd0, bus_op}, 64'd0);
    chk("rst_bus_addr", {32'd0, bus_addr}, 64'd0);
    rstb = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i], 1'b0, 2'd0, 32'd0);
    end
`ifdef CACHE_BUS_STATS_EN
    chk("stat_ops", 64'(stat_ops), 64'd8);
    chk("stat_hitm", 64'(stat_hitm), 64'd2);
    chk("stat_timeouts", 64'(stat_timeouts), 64'd1);
`endif

    // Back-to-back with req_valid held: second op only after the first done.
    b1 = '{"b2b_first", READ, 32'h0000_8000, 0, 2'd1, 1, 1'b1, 1'b0, 4, 1};
    b2 = '{"b2b_second", UPGRADE, 32'h0000_9000, 0, 2'd0, 0, 1'b0, 1'b0, 3, 0};
    run_op(b1, 1'b1, b2.op, b2.addr);
    run_op(b2, 1'b0, 2'd0, 32'd0);

    // Reset asserted while waiting in MEM drops the operation.
    req_valid = 1'b1; req_op = RFO; req_addr = 32'h0000_A000;
    chk("mrst_accept_ready", {63'd0, req_ready}, 64'd1);
    @(negedge clk); req_valid = 1'b0; bus_gnt = 1'b1;             // ARB
    @(negedge clk); bus_gnt = 1'b0; bus_snoop = 2'd2;             // ADDR
    @(negedge clk); bus_snoop = 2'd0;                              // MEM 1
    chk("mrst_mem_valid", {63'd0, mem_valid}, 64'd1);
    chk("mrst_mem_busreq", {63'd0, bus_req}, 64'd1);
    @(negedge clk);                                                // MEM 2
    #1 rstb = 1'b0;
    #1;
    chk("mrst_async_memvalid", {63'd0, mem_valid}, 64'd0);
    chk("mrst_async_busreq", {63'd0, bus_req}, 64'd0);
    chk("mrst_async_done", {63'd0, done}, 64'd0);
`ifdef CACHE_BUS_STATS_EN
    chk("mrst_stat_hitm", 64'(stat_hitm), 64'd0);
`endif
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    ncyc = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) ncyc++;
    end
    chk("mrst_no_done", 64'(ncyc), 64'd0);
    chk("mrst_ready_after", {63'd0, req_ready}, 64'd1);

    up = '{"post_rst_upg", UPGRADE, 32'h0000_B000, 1, 2'd1, 0, 1'b0, 1'b0, 4, 0};
    run_op(up, 1'b0, 2'd0, 32'd0);
`ifdef CACHE_BUS_STATS_EN
    chk("post_rst_stat_ops", 64'(stat_ops), 64'd1);
`endif

    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cache_bus_ctrl
`default_nettype wire

// File: doc/cache_bus_ctrl.md
CACHE_BUS_CTRL -- requirements
Module: cache_bus_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter MEM_TIMEOUT, default 255, maximum cycles to wait for mem_ready before error.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rstb  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  cache presents a bus operation.
REQ-006 req_ready  output  1  controller accepts the request; transfer when req_valid && req_ready.
REQ-007 req_op  input  2  0 READ (BusRd), 1 RFO (BusRdX), 2 UPGRADE (BusUpgr), 3 WRITEBACK (Flush).
REQ-008 req_addr  input  ADDR_W  line address of the operation.
REQ-009 done  output  1  one-cycle pulse when the operation completes.
REQ-010 shared  output  1  C_in to the MESI FSM; valid while done=1.
REQ-011 err  output  1  one-cycle pulse with done when the memory timeout expires.
REQ-012 bus_req  output  1  arbitration request.
REQ-013 bus_gnt  input  1  arbitration grant.
REQ-014 bus_op  output  2  bus operation encoding, same as req_op; valid in ADDR only.
REQ-015 bus_addr  output  ADDR_W  bus address; valid in ADDR only.
REQ-016 bus_snoop  input  2  snoop result sampled in ADDR: 0 NOHIT, 1 HIT, 2 HITM, 3 treated as NOHIT.
REQ-017 mem_valid  output  1  memory transfer request.
REQ-018 mem_ready  input  1  memory transfer complete.

Function
REQ-019 States: IDLE, ARB, ADDR, MEM, DONE.
REQ-020 req_ready is 1 only in IDLE, so at most one operation is outstanding.
REQ-021 Acceptance:
- On acceptance, op and address are registered.
- IDLE moves to ARB the next cycle.
REQ-022 ARB:
- bus_req is held at 1 until bus_gnt=1 is sampled; bus_gnt=0 keeps the FSM in ARB indefinitely.
- When bus_gnt=1, the FSM moves to ADDR.
REQ-023 ADDR lasts exactly one cycle:
- bus_op and bus_addr are driven.
- bus_snoop is registered.
- bus_req stays 1.
REQ-024 From ADDR, UPGRADE goes directly to DONE; READ, RFO and WRITEBACK go to MEM.
REQ-025 HITM on READ or RFO still goes to MEM; the owner's flush is serviced by memory, and the controller waits for mem_ready.
REQ-026 MEM:
- mem_valid=1 until mem_ready=1 is sampled.
- mem_ready=1 on the first MEM cycle completes in that cycle.
REQ-027 MEM timeout:
- A counter clears on MEM entry.
- When the counter reaches MEM_TIMEOUT without mem_ready, the FSM goes to DONE with err=1.
REQ-028 DONE lasts one cycle:
- done=1, bus_req=0.
- shared=1 if the sampled snoop was HIT or HITM and op is READ; otherwise shared=0.
- The FSM then returns to IDLE.
REQ-029 Latency: acceptance to done is at least 3 cycles (UPGRADE with immediate grant) and at least 4 cycles with memory.
REQ-030 mem_ready or bus_gnt outside the state that waits for it is ignored.
REQ-031 bus_op and bus_addr are 0 outside ADDR.

Reset
REQ-032 When rstb=0, the FSM returns to IDLE asynchronously, mid-operation included; the in-flight operation is dropped with no done.
REQ-033 Reset values:
- Outputs: req_ready=1; done, shared, err, bus_req, mem_valid=0; bus_op, bus_addr=0.
- Internal registers: counters, registered op, address and snoop are 0.

Configuration
REQ-034 Macro CACHE_BUS_STATS_EN.
REQ-035 When CACHE_BUS_STATS_EN is defined, it adds three 32-bit saturating counters:
- stat_ops, incremented at done.
- stat_hitm, incremented when HITM is sampled.
- stat_timeouts, incremented at err.
- Counters are output ports, reset to 0, and hold at 0xFFFFFFFF.
REQ-036 When CACHE_BUS_STATS_EN is undefined, those ports and their logic are absent and all other behaviour is identical.

Structure
REQ-037 Package cache_bus_pkg holds:
- bus_op_t enum: READ, RFO, UPGRADE, WRITEBACK.
- snoop_t enum: NOHIT, HIT, HITM.
- bus_state_t enum: the FSM states.
- Constants NOHIT=0, HIT=1, HITM=2.
REQ-038 Sub-module cache_bus_timeout holds the MEM wait counter, with clear, enable and expired signals; everything else is in cache_bus_ctrl.

Verification
REQ-039 READ 0x0000_1040, bus_gnt after 2 cycles, snoop HIT, mem_ready on the 1st MEM cycle -> bus_op=0 and bus_addr=0x1040 in ADDR; done with shared=1; 6 cycles from acceptance.
REQ-040 UPGRADE 0xDEAD_BEC0, immediate grant -> mem_valid never asserted; done 3 cycles after acceptance with shared=0.
REQ-041 RFO with snoop HITM, mem_ready after 5 cycles -> mem_valid high exactly 5 cycles; shared=0; stat_hitm=1 when STATS enabled.
REQ-042 WRITEBACK with mem_ready never asserted -> after MEM_TIMEOUT=255 cycles, done=1 and err=1 in the same cycle; FSM back in IDLE.
REQ-043 rstb pulled low while in MEM -> mem_valid, bus_req=0 immediately; no done; req_ready=1 after reset release.
REQ-044 req_valid held high through two back-to-back ops -> the 2nd op is accepted only in the cycle after the 1st done; there is never more than one bus_req episode at a time.
